// File: rtl/lab_digitize_sched.sv
// LAB digitization scheduler: latches HOLD edges from the four TURF buffers and grants them one at a time, round-robin, to LAB_TOPv2.
// Optional digitize abort timer enabled by defining SCHED_TIMEOUT_EN.
module lab_digitize_sched #(
    parameter int NBUF           = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TO_WIDTH       = 12
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NBUF-1:0] hold_i,
    input  logic [NBUF-1:0] clear_i,
    input  logic            done_i,
    output logic [NBUF-1:0] digitize_o,
    output logic [NBUF-1:0] ready_o,
    output logic            busy_o,
    output logic            drop_o,
    output logic            timeout_o
);

    localparam int LW = (NBUF > 1) ? $clog2(NBUF) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [NBUF-1:0] hold_q_reg;
    logic [NBUF-1:0] pending_reg, pending_next;
    logic [NBUF-1:0] ready_reg, ready_next;
    logic [NBUF-1:0] digitize_reg, digitize_next;
    logic [LW-1:0]   grant_reg, grant_next;
    logic [LW-1:0]   last_reg, last_next;
    logic            drop_reg, drop_next;

    logic [NBUF-1:0] hold_edge;
    logic [NBUF-1:0] granted_mask;
    logic [NBUF-1:0] free_mask;
    logic [NBUF-1:0] accept_mask;
    logic [NBUF-1:0] reject_mask;
    logic [NBUF-1:0] retire_mask;
    logic [NBUF-1:0] ready_set;
    logic [LW-1:0]   sel;
    logic            sel_valid;
    logic            expire;

    // The counter must be able to reach TIMEOUT_CYCLES-1.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TO_WIDTH)) begin : g_bad_timeout_param
        $error("lab_digitize_sched: TO_WIDTH cannot hold TIMEOUT_CYCLES");
    end

    // Only an active grant makes its buffer busy; in IDLE the stale grant_reg means nothing.
    assign granted_mask = (state_reg != IDLE) ? (NBUF'(1) << grant_reg) : '0;

    // A clear in the same cycle frees the buffer before the edge is judged.
    for (genvar gi = 0; gi < NBUF; gi++) begin : g_buf
        assign hold_edge[gi]   = hold_i[gi] & ~hold_q_reg[gi];
        assign free_mask[gi]   = ~pending_reg[gi] & ~(ready_reg[gi] & ~clear_i[gi]) & ~granted_mask[gi];
        assign accept_mask[gi] = hold_edge[gi] & free_mask[gi];
        assign reject_mask[gi] = hold_edge[gi] & ~free_mask[gi];
    end

    // Round-robin: first pending bit searching upward from last+1, wrapping.
    always_comb begin
        int idx;
        sel       = last_reg;
        sel_valid = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NBUF; i++) begin
            idx = (int'(last_reg) + i) % NBUF;
            if (!sel_valid && pending_reg[idx]) begin
                sel       = LW'(idx);
                sel_valid = 1'b1;
            end
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt_reg;
    logic                timeout_reg;

    assign expire = (state_reg == REQ) && !done_i &&
                    (to_cnt_reg == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg <= (state_reg == REQ) ? to_cnt_reg + 1'b1 : '0;
            if (expire)
                timeout_reg <= 1'b1;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!done_i && sel_valid) state_next = REQ;
            REQ:     if (done_i || expire)     state_next = SETTLE;
            SETTLE:  if (!done_i)              state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    always_comb begin
        digitize_next = digitize_reg;
        grant_next    = grant_reg;
        last_next     = last_reg;
        retire_mask   = '0;
        ready_set     = '0;
        case (state_reg)
            IDLE: begin
                if (!done_i && sel_valid) begin
                    grant_next    = sel;
                    last_next     = sel;
                    digitize_next = NBUF'(1) << sel;
                end
            end
            REQ: begin
                if (done_i) begin
                    digitize_next = '0;
                    retire_mask   = granted_mask;
                    ready_set     = granted_mask;
                end else if (expire) begin
                    digitize_next = '0;
                    retire_mask   = granted_mask;
                end
            end
            default: ;
        endcase
        pending_next = (pending_reg | accept_mask) & ~retire_mask;
        ready_next   = (ready_reg & ~clear_i) | ready_set;
        drop_next    = |reject_mask;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q_reg   <= '0;
            pending_reg  <= '0;
            ready_reg    <= '0;
            digitize_reg <= '0;
            grant_reg    <= '0;
            last_reg     <= LW'(NBUF - 1);
            drop_reg     <= 1'b0;
        end else begin
            hold_q_reg   <= hold_i;
            pending_reg  <= pending_next;
            ready_reg    <= ready_next;
            digitize_reg <= digitize_next;
            grant_reg    <= grant_next;
            last_reg     <= last_next;
            drop_reg     <= drop_next;
        end
    end

    assign digitize_o = digitize_reg;
    assign ready_o    = ready_reg;
    assign busy_o     = (state_reg != IDLE);
    assign drop_o     = drop_reg;

endmodule

// File: tb/tb_lab_digitize_sched.sv
// Directed self-checking bench for lab_digitize_sched: reset, latency, round-robin order, drops, done-stuck and (optionally) timeout.
`timescale 1ns/1ps
module tb_lab_digitize_sched;

    localparam int NBUF = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [NBUF-1:0] hold_i = '0;
    logic [NBUF-1:0] clear_i = '0;
    logic            done_i = 1'b0;
    logic [NBUF-1:0] digitize_o;
    logic [NBUF-1:0] ready_o;
    logic            busy_o;
    logic            drop_o;
    logic            timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [NBUF-1:0] ready_model = '0;

    lab_digitize_sched #(
        .NBUF(NBUF),
        .TIMEOUT_CYCLES(16),
        .TO_WIDTH(5)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .hold_i(hold_i),
        .clear_i(clear_i),
        .done_i(done_i),
        .digitize_o(digitize_o),
        .ready_o(ready_o),
        .busy_o(busy_o),
        .drop_o(drop_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        hold_i  = '0;
        clear_i = '0;
        done_i  = 1'b0;
        ready_model = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Bounded wait for the next grant, then compare it with the expected one-hot.
    task automatic wait_grant(input logic [NBUF-1:0] exp, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (digitize_o != '0) break;
            tick();
        end
        check(tag, 32'(digitize_o), 32'(exp));
    endtask

    task automatic complete(input logic [NBUF-1:0] g, input string tag);
        done_i = 1'b1;
        tick();
        ready_model |= g;
        check({tag, "_dig_off"}, 32'(digitize_o), 32'h0);
        check({tag, "_ready"}, 32'(ready_o), 32'(ready_model));
        done_i = 1'b0;
        tick();
        check({tag, "_idle_gap"}, 32'(busy_o), 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_dig", 32'(digitize_o), 32'h0);
        check("rst_ready", 32'(ready_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_drop", 32'(drop_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        do_reset();

        // 1: reset while in REQ
        hold_i = 4'b0001;
        tick();
        wait_grant(4'b0001, "t1_grant0");
        #2;
        rst_i = 1'b1;
        #1;
        check("t1_async_dig", 32'(digitize_o), 32'h0);
        check("t1_async_ready", 32'(ready_o), 32'h0);
        check("t1_async_busy", 32'(busy_o), 32'h0);
        hold_i = '0;
        tick();
        rst_i = 1'b0;
        tick(); tick(); tick();
        check("t1_post_busy", 32'(busy_o), 32'h0);
        check("t1_post_dig", 32'(digitize_o), 32'h0);

        // 3: round-robin from last=3
        hold_i = 4'b1011;
        tick();
        wait_grant(4'b0001, "t3_g0");
        complete(4'b0001, "t3_c0");
        hold_i  = 4'b1010;
        clear_i = 4'b0001;
        tick();
        ready_model &= ~4'b0001;
        clear_i = '0;
        hold_i  = 4'b1011;
        tick();
        wait_grant(4'b0010, "t3_g1");
        complete(4'b0010, "t3_c1");
        wait_grant(4'b1000, "t3_g3");
        complete(4'b1000, "t3_c3");
        wait_grant(4'b0001, "t3_g0b");
        complete(4'b0001, "t3_c0b");
        clear_i = 4'b1011;
        hold_i  = '0;
        tick();
        ready_model = '0;
        clear_i = '0;
        check("t3_cleared", 32'(ready_o), 32'h0);

        // 2: single event latency
        hold_i = 4'b0100;
        tick();
        tick();
        check("t2_latency", 32'(digitize_o), 32'h4);
        check("t2_busy", 32'(busy_o), 32'h1);
        complete(4'b0100, "t2");
        clear_i = 4'b0100;
        tick();
        ready_model = '0;
        clear_i = '0;
        hold_i  = '0;
        check("t2_clear", 32'(ready_o), 32'h0);

        // 4: drop on ready buffer, then clear+edge accepted
        tick();
        hold_i = 4'b0010;
        tick();
        wait_grant(4'b0010, "t4_grant");
        complete(4'b0010, "t4");
        hold_i = '0;
        tick();
        hold_i = 4'b0010;
        tick();
        check("t4_drop_pulse", 32'(drop_o), 32'h1);
        tick();
        check("t4_drop_once", 32'(drop_o), 32'h0);
        check("t4_no_grant", 32'(busy_o), 32'h0);
        tick();
        check("t4_no_dig", 32'(digitize_o), 32'h0);
        hold_i = '0;
        tick();
        hold_i  = 4'b0010;
        clear_i = 4'b0010;
        tick();
        ready_model = '0;
        clear_i = '0;
        check("t4_clr_edge_nodrop", 32'(drop_o), 32'h0);
        check("t4_clr_ready", 32'(ready_o), 32'h0);
        tick();
        check("t4_accepted", 32'(digitize_o), 32'h2);
        complete(4'b0010, "t4b");
        clear_i = 4'b0010;
        hold_i  = '0;
        tick();
        ready_model = '0;
        clear_i = '0;

        // 5: done stuck high in IDLE
        done_i = 1'b1;
        hold_i = 4'b1000;
        tick(); tick(); tick();
        check("t5_held_dig", 32'(digitize_o), 32'h0);
        check("t5_held_busy", 32'(busy_o), 32'h0);
        done_i = 1'b0;
        tick();
        check("t5_release", 32'(digitize_o), 32'h8);
        complete(4'b1000, "t5");
        clear_i = 4'b1000;
        hold_i  = '0;
        tick();
        ready_model = '0;
        clear_i = '0;
        check("t5_timeout_clear", 32'(timeout_o), 32'h0);

`ifdef SCHED_TIMEOUT_EN
        // 6: timeout expiry, then done winning on the expiry cycle
        do_reset();
        hold_i = 4'b1000;
        tick();
        wait_grant(4'b1000, "t6_grant3");
        repeat (15) tick();
        hold_i = 4'b1001;
        check("t6_still_req", 32'(digitize_o), 32'h8);
        tick();
        check("t6_abort_dig", 32'(digitize_o), 32'h0);
        check("t6_flag", 32'(timeout_o), 32'h1);
        check("t6_not_ready", 32'(ready_o), 32'h0);
        tick();
        wait_grant(4'b0001, "t6_next");
        complete(4'b0001, "t6_c0");
        do_reset();
        hold_i = 4'b1000;
        tick();
        wait_grant(4'b1000, "t6b_grant3");
        repeat (15) tick();
        done_i = 1'b1;
        tick();
        check("t6b_dig", 32'(digitize_o), 32'h0);
        check("t6b_ready", 32'(ready_o), 32'h8);
        check("t6b_noflag", 32'(timeout_o), 32'h0);
        done_i = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
